// File: rtl/bcd_pkg.sv
// Shared definitions for the BCD arithmetic datapath.
//   BCD_W   : width of one packed BCD digit
//   state_t : sequencing states of the digit-serial multiplier
//   is_bcd  : true when a 4-bit digit is a legal decimal digit (0..9)
package bcd_pkg;

  localparam int BCD_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  function automatic logic is_bcd(input logic [BCD_W-1:0] digit);
    return digit <= 4'd9;
  endfunction

endpackage

// File: rtl/bcd_mul_cell.sv
// One-digit BCD multiply-accumulate cell (combinational).
// Computes t = digit*m + cin and splits it into a decimal digit and a carry.
//   digit : BCD operand digit (0..9)
//   m     : BCD multiplier digit (0..9)
//   cin   : incoming decimal carry (0..8)
//   dout  : t mod 10
//   cout  : t div 10 (0..8)
module bcd_mul_cell
  import bcd_pkg::*;
(
  input  logic [BCD_W-1:0] digit,
  input  logic [BCD_W-1:0] m,
  input  logic [BCD_W-1:0] cin,
  output logic [BCD_W-1:0] dout,
  output logic [BCD_W-1:0] cout
);

  // 9*9 + 8 = 89 is the largest legal value, so 7 bits suffice.
  // Non-BCD inputs are filtered upstream and never reach this cell.
  logic [6:0] t;

  always_comb begin
    t    = 7'(digit) * 7'(m) + 7'(cin);
    dout = BCD_W'(t % 7'd10);
    cout = BCD_W'(t / 7'd10);
  end

endmodule

// File: rtl/bcd_digit_mul.sv
// Digit-serial BCD multiplier: NDIG-digit packed BCD operand times one BCD
// digit, producing an (NDIG+1)-digit packed BCD product. One operand digit
// is processed per clock through a single shared bcd_mul_cell.
//
//   state | meaning
//   IDLE  | waiting for start; operands latched on the accepting edge
//   RUN   | one operand digit multiplied per edge, carry rippled forward
//   DONE  | result (or error) valid; done pulses for this one cycle
//
// Ports:
//   clk   : clock, rising edge
//   rst   : synchronous active-high reset
//   start : request, sampled only in IDLE
//   a     : packed BCD operand, digit 0 at [3:0]
//   m     : BCD multiplier digit
//   busy  : high whenever not IDLE
//   done  : one-cycle result-valid pulse
//   err   : non-BCD digit seen on the last accepted start
//   p     : packed BCD product, held until the next accepted start
module bcd_digit_mul
  import bcd_pkg::*;
#(
  parameter int NDIG = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [BCD_W*NDIG-1:0]       a,
  input  logic [BCD_W-1:0]            m,
  output logic                        busy,
  output logic                        done,
  output logic                        err,
  output logic [BCD_W*(NDIG+1)-1:0]   p
);

  localparam int IDX_W = (NDIG > 1) ? $clog2(NDIG) : 1;

  state_t                       state_q, state_d;
  logic [IDX_W-1:0]             idx_q;
  logic [BCD_W*NDIG-1:0]        a_q;
  logic [BCD_W-1:0]             m_q;
  logic [BCD_W-1:0]             carry_q;
  logic [BCD_W*(NDIG+1)-1:0]    p_q;
  logic                         err_q;

  logic [BCD_W-1:0]             cur_digit;
  logic [BCD_W-1:0]             cell_dout;
  logic [BCD_W-1:0]             cell_cout;
  logic                         in_bad;
  logic                         accept;
  logic                         last_digit;

  always_comb begin
    in_bad = !is_bcd(m);
    for (int i = 0; i < NDIG; i++) begin
      if (!is_bcd(a[BCD_W*i +: BCD_W])) in_bad = 1'b1;
    end
  end

  assign accept     = (state_q == IDLE) && start;
  assign last_digit = (idx_q == IDX_W'(NDIG - 1));
  assign cur_digit  = a_q[BCD_W*idx_q +: BCD_W];

  bcd_mul_cell u_cell (
    .digit (cur_digit),
    .m     (m_q),
    .cin   (carry_q),
    .dout  (cell_dout),
    .cout  (cell_cout)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = in_bad ? DONE : RUN;
      RUN:     if (last_digit) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q     <= '0;
      m_q     <= '0;
      carry_q <= '0;
      idx_q   <= '0;
      p_q     <= '0;
      err_q   <= 1'b0;
    end else if (accept) begin
      a_q     <= a;
      m_q     <= m;
      carry_q <= '0;
      idx_q   <= '0;
      p_q     <= '0;
      err_q   <= in_bad;
    end else if (state_q == RUN) begin
      p_q[BCD_W*idx_q +: BCD_W] <= cell_dout;
      carry_q <= cell_cout;
      idx_q   <= idx_q + 1'b1;
      // The top product digit is just the carry out of the last operand digit.
      if (last_digit) p_q[BCD_W*NDIG +: BCD_W] <= cell_cout;
    end
  end

  assign busy = (state_q != IDLE);
  assign done = (state_q == DONE);
  assign err  = err_q;
  assign p    = p_q;

endmodule

// File: tb/tb_bcd_digit_mul.sv
module tb_bcd_digit_mul;

  localparam int NDIG = 4;
  localparam int AW   = 4 * NDIG;
  localparam int PW   = 4 * (NDIG + 1);
  localparam int BOUND = 50;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW-1:0] a;
  logic [3:0]    m;
  logic          busy;
  logic          done;
  logic          err;
  logic [PW-1:0] p;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [PW-1:0] p;
    logic          err;
  } exp_t;

  exp_t sb[$];
  exp_t popped;

  always #5 clk = ~clk;

  bcd_digit_mul #(.NDIG(NDIG)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .m     (m),
    .busy  (busy),
    .done  (done),
    .err   (err),
    .p     (p)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: convert to an integer, multiply, convert back to BCD.
  function automatic exp_t model(input logic [AW-1:0] av, input logic [3:0] mv);
    exp_t r;
    int   val  = 0;
    int   prod;
    logic bad  = (mv > 4'd9);
    for (int i = NDIG - 1; i >= 0; i--) begin
      if (av[4*i +: 4] > 4'd9) bad = 1'b1;
      val = val * 10 + int'(av[4*i +: 4]);
    end
    r.err = bad;
    r.p   = '0;
    if (!bad) begin
      prod = val * int'(mv);
      for (int i = 0; i <= NDIG; i++) begin
        r.p[4*i +: 4] = 4'(prod % 10);
        prod = prod / 10;
      end
    end
    return r;
  endfunction

  // Scoreboard: every done pulse must match the oldest outstanding request.
  always begin
    @(posedge clk); #1;
    if (done) begin
      if (sb.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        popped = sb.pop_front();
        check("p", 32'(p), 32'(popped.p));
        check("err", 32'(err), 32'(popped.err));
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    while (busy !== 1'b0 && n < BOUND) begin
      @(posedge clk); #1; n++;
    end
    if (n >= BOUND) check("idle_timeout", 32'(n), 32'(BOUND - 1));
  endtask

  // One operation; optionally pokes a second start while RUN is in progress.
  task automatic run_op(input logic [AW-1:0] av, input logic [3:0] mv, input bit poke);
    exp_t e;
    int   lat;
    int   busy_cyc;
    wait_idle();
    @(negedge clk);
    start = 1'b1; a = av; m = mv;
    e = model(av, mv);
    sb.push_back(e);
    @(posedge clk); #1;
    start = 1'b0;
    a = AW'($urandom); m = 4'($urandom);
    lat = 0; busy_cyc = 0;
    while (done !== 1'b1 && lat < BOUND) begin
      if (busy === 1'b1) busy_cyc++;
      if (poke && lat == 1) begin
        start = 1'b1; a = 16'h8888; m = 4'd7;
      end
      if (poke && lat == 2) start = 1'b0;
      @(posedge clk); #1; lat++;
    end
    if (busy === 1'b1) busy_cyc++;
    check("latency", 32'(lat), e.err ? 32'd0 : 32'(NDIG));
    check("busy_cycles", 32'(busy_cyc), e.err ? 32'd1 : 32'(NDIG + 1));
    @(posedge clk); #1;
    check("busy_after_done", 32'(busy), 32'd0);
    check("done_after_done", 32'(done), 32'd0);
  endtask

  initial begin
    int n;
    rst = 1'b1; start = 1'b0; a = '0; m = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err",  32'(err),  32'd0);
    check("rst_p",    32'(p),    32'd0);
    @(negedge clk); rst = 1'b0;

    run_op(16'h1234, 4'd5, 1'b0);
    run_op(16'h9999, 4'd9, 1'b0);
    run_op(16'h0000, 4'd7, 1'b0);
    run_op(16'h4321, 4'd0, 1'b0);
    run_op(16'h4321, 4'd1, 1'b0);
    run_op(16'h12A4, 4'd3, 1'b0);
    run_op(16'h0002, 4'd4, 1'b0);
    run_op(16'h5678, 4'd12, 1'b0);
    run_op(16'h0705, 4'd8, 1'b0);
    run_op(16'h2468, 4'd3, 1'b1);

    // Start held high: back-to-back operations one IDLE cycle apart.
    wait_idle();
    @(negedge clk);
    start = 1'b1; a = 16'h1111; m = 4'd2;
    sb.push_back(model(16'h1111, 4'd2));
    @(posedge clk); #1;
    a = 16'h2222; m = 4'd3;
    sb.push_back(model(16'h2222, 4'd3));
    n = 0;
    while (done !== 1'b1 && n < BOUND) begin @(posedge clk); #1; n++; end
    check("held_lat1", 32'(n), 32'(NDIG));
    @(posedge clk); #1;
    check("held_gap_idle", 32'(busy), 32'd0);
    @(posedge clk); #1;
    check("held_retrigger", 32'(busy), 32'd1);
    start = 1'b0;
    n = 0;
    while (done !== 1'b1 && n < BOUND) begin @(posedge clk); #1; n++; end
    check("held_lat2", 32'(n), 32'(NDIG));

    // Reset during the second RUN cycle discards the operation.
    wait_idle();
    @(negedge clk);
    start = 1'b1; a = 16'h9999; m = 4'd9;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_p",    32'(p),    32'd0);
    check("midrst_err",  32'(err),  32'd0);
    repeat (NDIG + 3) @(posedge clk);
    run_op(16'h9999, 4'd9, 1'b0);

    repeat (3) @(posedge clk);
    #1;
    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bcd_digit_mul.md
Name: bcd_digit_mul

Overview:
- Digit-serial multiplier: N-digit packed BCD operand times one BCD digit; result is (N+1)-digit packed BCD.
- Parametrised sequential successor of the team's fixed ×5 single-digit BCD converter: multiplier is a runtime input, operand width is a parameter, invalid BCD is detected.
- Sits in the BCD arithmetic datapath; feeds display or accumulation logic via a start/done handshake.

Parameters:
- NDIG, 4, operand digit count (≥1); result has NDIG+1 digits.

Ports:
- clk  in  1  clock, all state changes on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  request; sampled only in IDLE
- a  in  4*NDIG  packed BCD operand, digit 0 at [3:0]
- m  in  4  BCD multiplier digit
- busy  out  1  high whenever state != IDLE
- done  out  1  one-cycle pulse: result valid
- err  out  1  invalid BCD digit seen on last accepted start; held until next accepted start
- p  out  4*(NDIG+1)  packed BCD product; held until next accepted start

Behaviour:
- Reset (clk edge with rst=1): state IDLE, busy=0, done=0, err=0, p=0, carry=0, digit index=0, operand registers=0. Reset overrides everything, including mid-operation; partial result is discarded, p reads 0.
- States: IDLE, RUN, DONE.
- IDLE: start=1 at edge → latch a and m, clear p and err, index=0, carry=0.
  - If any digit of a >9 or m >9: err=1, p stays 0, go to DONE (done one cycle later).
  - Otherwise go to RUN.
  - start=0: stay in IDLE.
- RUN, one digit per edge: t = a[idx]*m + carry (range 0..89, 7-bit intermediate); p digit idx = t mod 10; carry = t div 10 (0..8); idx++.
  - On the edge that processes idx=NDIG-1: also write the final carry into digit NDIG of p, then go to DONE.
- DONE: done=1 for exactly this cycle, busy=1; next edge → IDLE.
- Latency: start edge E0; done is high during the cycle after edge E(NDIG+1)−1, i.e. NDIG+1 cycles after start is sampled. Error path: done is high in the cycle after E0.
- Intermediate digit values of p are visible during RUN; p is guaranteed valid only from the done cycle until the next accepted start.
- start while busy (RUN or DONE) is ignored and is not queued; a start held high continuously re-triggers in the first IDLE cycle.
- Changes on a or m after acceptance have no effect on the operation.
- m=0 gives an all-zero product; m=1 gives p = {0, a}. No overflow is possible: max 99..9×9 fits in NDIG+1 digits.

Decomposition:
- Package bcd_pkg: BCD_W=4 constant; state enum {IDLE, RUN, DONE}; function is_bcd(digit).
- Sub-module bcd_mul_cell (combinational): inputs digit, m, cin[3:0]; outputs dout[3:0], cout[3:0]. It computes t = digit*m + cin, then dout = t mod 10 and cout = t div 10. Instantiate once and time-multiplex it across digits.

Test Plan:
- NDIG=4, a=16'h1234, m=5, start one cycle → done in cycle 5 after start, p=20'h06170, err=0, busy high for 5 cycles.
- a=16'h9999, m=9 → p=20'h89991 (max carry chain), err=0.
- a=16'h0000, m=7, then a=16'h4321, m=0 → p=0 for both; then a=16'h4321, m=1 → p=20'h04321.
- a=16'h12A4, m=3 → done the cycle after start, err=1, p=0. Follow with a valid start (a=16'h0002, m=4) → err clears, p=20'h00008.
- start pulsed again during RUN with different operands → ignored, first result intact; start held high → back-to-back operations, one IDLE cycle apart.
- rst asserted in the 2nd RUN cycle of a=16'h9999, m=9 → next cycle state IDLE, busy=0, done=0, p=0; a subsequent start completes correctly.
